// File: rtl/i2c_slave.sv
// I2C target oversampled on clk_sys-style system clock: START/STOP decode, 7-bit address match,
// byte receive with ACK, and byte transmit from a locally supplied tx_data.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       tx_load,
  output logic       busy,
  output logic [3:0] state
);

  // state      | meaning
  // IDLE       | bus free or not addressed, waiting for START
  // ADDR       | shifting in 7-bit address + R/W
  // ADDR_ACK   | driving ACK for a matched address
  // WRITE      | shifting in a data byte from the master
  // WRITE_ACK  | driving ACK for a received data byte
  // READ       | serialising tx_data onto sda, MSB first
  // READ_ACK   | sda released, sampling master ACK/NACK
  // IGNORE     | address mismatch, waiting for START or STOP
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_WRITE_ACK = 4'd4,
    ST_READ      = 4'd5,
    ST_READ_ACK  = 4'd6,
    ST_IGNORE    = 4'd7
  } state_t;

  logic   scl_s1, scl_s2, scl_d;
  logic   sda_s1, sda_s2, sda_d;
  logic   scl_rise, scl_fall, start_det, stop_det;

  state_t state_q, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shifter, shifter_n;
  logic [7:0] data_out_n;
  logic       rw, rw_n;
  logic       sda_oe, sda_oe_n;
  logic       data_valid_n, tx_load_n, busy_n;

  // Synchronisers idle high so that reset release never fakes a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= sclk;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shifter    <= 8'h00;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt    <= bit_cnt_n;
      shifter    <= shifter_n;
      rw         <= rw_n;
      sda_oe     <= sda_oe_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      tx_load    <= tx_load_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    bit_cnt_n    = bit_cnt;
    shifter_n    = shifter;
    rw_n         = rw;
    sda_oe_n     = sda_oe;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    tx_load_n    = 1'b0;
    busy_n       = busy;

    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      shifter_n = 8'h00;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shifter_n = {shifter[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (shifter[7:1] == ADDR) begin
              state_n  = ST_ADDR_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shifter[0];
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            if (rw) begin
              state_n   = ST_READ;
              shifter_n = tx_data;
              tx_load_n = 1'b1;
              sda_oe_n  = ~tx_data[7];
              bit_cnt_n = 4'd1;
            end else begin
              state_n = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shifter_n = {shifter[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              data_out_n   = {shifter[6:0], sda_s2};
              data_valid_n = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n   = ST_WRITE_ACK;
            sda_oe_n  = 1'b1;
            bit_cnt_n = 4'd0;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            state_n  = ST_WRITE;
            sda_oe_n = 1'b0;
          end
        end
        // bit_cnt counts bits already presented; bit 7 went out on entry.
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n  = ST_READ_ACK;
              sda_oe_n = 1'b0;
            end else begin
              shifter_n = {shifter[6:0], 1'b0};
              sda_oe_n  = ~shifter[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        // A falling edge is only reached here after an ACK was sampled on the rise.
        ST_READ_ACK: begin
          if (scl_rise && sda_s2) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
          end else if (scl_fall) begin
            state_n   = ST_READ;
            shifter_n = tx_data;
            tx_load_n = 1'b1;
            sda_oe_n  = ~tx_data[7];
            bit_cnt_n = 4'd1;
          end
        end
        ST_IGNORE: ;
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  assign sda   = sda_oe ? 1'b0 : 1'bz;
  assign state = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on sclk/sda with a pull-up,
// immediate assertions against hand-computed values.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] data_out;
  logic       data_valid, tx_load, busy;
  logic [3:0] state;
  wire        sda;

  int vectors = 0;
  int errors  = 0;
  int dv_cnt  = 0;
  int txl_cnt = 0;
  int low_cnt = 0;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.ADDR(7'h42)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .sda        (sda),
    .tx_data    (tx_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tx_load    (tx_load),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (tx_load) txl_cnt <= txl_cnt + 1;
    if (sda == 1'b0 && !m_low) low_cnt <= low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_low = ~b;
    wait_clk(5);
    sclk = 1'b1;
    wait_clk(5);
    r = sda;
    wait_clk(5);
    sclk = 1'b0;
    wait_clk(5);
  endtask

  task automatic start_c();
    wait_clk(5);
    m_low = 1'b1;
    wait_clk(5);
    sclk = 1'b0;
    wait_clk(5);
  endtask

  task automatic rstart_c();
    m_low = 1'b0;
    wait_clk(5);
    sclk = 1'b1;
    wait_clk(5);
    m_low = 1'b1;
    wait_clk(5);
    sclk = 1'b0;
    wait_clk(5);
  endtask

  task automatic stop_c();
    m_low = 1'b1;
    wait_clk(5);
    sclk = 1'b1;
    wait_clk(5);
    m_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         dv0, txl0, low0;

    wait_clk(5);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_dv_txl_busy", {29'd0, data_valid, tx_load, busy}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    wait_clk(5);

    // write 0xA5 to 0x42
    dv0 = dv_cnt;
    start_c();
    check("wr_after_start", {28'd0, state}, 32'd1);
    send_byte(8'h84, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd0);
    check("wr_state", {28'd0, state}, 32'd3);
    check("wr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hA5, ack);
    check("wr_data_ack", {31'd0, ack}, 32'd0);
    check("wr_data_out", {24'd0, data_out}, 32'hA5);
    check("wr_dv_pulses", dv_cnt - dv0, 32'd1);
    stop_c();
    check("wr_stop_state", {28'd0, state}, 32'd0);
    check("wr_stop_busy", {31'd0, busy}, 32'd0);

    // address mismatch 0x43
    dv0 = dv_cnt;
    low0 = low_cnt;
    start_c();
    send_byte(8'h86, ack);
    check("mm_addr_nack", {31'd0, ack}, 32'd1);
    check("mm_state", {28'd0, state}, 32'd7);
    check("mm_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h11, ack);
    check("mm_data_nack", {31'd0, ack}, 32'd1);
    check("mm_state2", {28'd0, state}, 32'd7);
    check("mm_no_dv", dv_cnt - dv0, 32'd0);
    check("mm_no_low", low_cnt - low0, 32'd0);
    check("mm_data_out_held", {24'd0, data_out}, 32'hA5);
    stop_c();
    check("mm_stop_state", {28'd0, state}, 32'd0);

    // read 0x3C, master NACK
    tx_data = 8'h3C;
    txl0 = txl_cnt;
    start_c();
    send_byte(8'h85, ack);
    check("rn_addr_ack", {31'd0, ack}, 32'd0);
    check("rn_state", {28'd0, state}, 32'd5);
    check("rn_busy", {31'd0, busy}, 32'd1);
    read_bits(d);
    check("rn_byte", {24'd0, d}, 32'h3C);
    bit_x(1'b1, r);
    check("rn_nack_state", {28'd0, state}, 32'd0);
    check("rn_nack_busy", {31'd0, busy}, 32'd0);
    check("rn_sda_released", {31'd0, sda}, 32'd1);
    check("rn_txl_pulses", txl_cnt - txl0, 32'd1);
    stop_c();
    check("rn_stop_state", {28'd0, state}, 32'd0);

    // two-byte read, master ACKs the first
    tx_data = 8'h3C;
    txl0 = txl_cnt;
    start_c();
    send_byte(8'h85, ack);
    check("ra_addr_ack", {31'd0, ack}, 32'd0);
    read_bits(d);
    check("ra_byte1", {24'd0, d}, 32'h3C);
    tx_data = 8'hF0;
    bit_x(1'b0, r);
    check("ra_after_ack_state", {28'd0, state}, 32'd5);
    read_bits(d);
    check("ra_byte2", {24'd0, d}, 32'hF0);
    bit_x(1'b1, r);
    check("ra_txl_pulses", txl_cnt - txl0, 32'd2);
    check("ra_nack_state", {28'd0, state}, 32'd0);
    stop_c();

    // write 0x55 then repeated START into a read
    tx_data = 8'h9A;
    start_c();
    send_byte(8'h84, ack);
    check("rs_waddr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h55, ack);
    check("rs_wdata_ack", {31'd0, ack}, 32'd0);
    rstart_c();
    check("rs_after_rstart", {28'd0, state}, 32'd1);
    send_byte(8'h85, ack);
    check("rs_raddr_ack", {31'd0, ack}, 32'd0);
    check("rs_data_out", {24'd0, data_out}, 32'h55);
    check("rs_state", {28'd0, state}, 32'd5);
    check("rs_busy", {31'd0, busy}, 32'd1);
    read_bits(d);
    check("rs_rbyte", {24'd0, d}, 32'h9A);
    bit_x(1'b1, r);
    stop_c();
    check("rs_stop_state", {28'd0, state}, 32'd0);

    // reset while the address ACK is being driven
    start_c();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h84;
      bit_x(d[i], r);
    end
    m_low = 1'b0;
    wait_clk(1);
    check("ra_mid_ack_sda", {31'd0, sda}, 32'd0);
    check("ra_mid_ack_state", {28'd0, state}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rm_sda_z", {31'd0, sda}, 32'd1);
    check("rm_state", {28'd0, state}, 32'd0);
    check("rm_data_out", {24'd0, data_out}, 32'h00);
    check("rm_dv_txl_busy", {29'd0, data_valid, tx_load, busy}, 32'd0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    stop_c();
    check("rm_idle", {28'd0, state}, 32'd0);
    dv0 = dv_cnt;
    start_c();
    send_byte(8'h84, ack);
    check("rm_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h69, ack);
    check("rm_data_ack", {31'd0, ack}, 32'd0);
    check("rm_data_out2", {24'd0, data_out}, 32'h69);
    check("rm_dv_pulses", dv_cnt - dv0, 32'd1);
    stop_c();
    check("rm_final_state", {28'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
